// File: rtl/pipe_mmio_pkg.sv
// Shared definitions for the MEM-stage data memory / MMIO block.
// Provides the I/O word offsets, the address region decoder and the byte-lane merge helper.
// No ports; imported by pipe_datamem_mmio.
package pipe_mmio_pkg;

   // Word offsets (addr[6:2]) inside the I/O window.
   localparam int OFS_OUT  = 0;
   localparam int OFS_IN   = 8;
   localparam int OFS_STAT = 16;
   localparam int OFS_MASK = 17;

   typedef enum logic [2:0] {
      RGN_RAM,
      RGN_OUT,
      RGN_IN,
      RGN_STAT,
      RGN_MASK,
      RGN_NONE
   } region_t;

   // Classify a byte address. addr[io_bit] picks RAM (0) or I/O (1);
   // inside I/O only addr[6:2] matters, everything unmapped is RGN_NONE.
   function automatic region_t region_decode(input logic [31:0] addr,
                                             input int          io_bit,
                                             input int          n_out,
                                             input int          n_in);
      int ofs;
      ofs = int'(addr[6:2]);
      if (!addr[io_bit])
         return RGN_RAM;
      if (ofs >= OFS_OUT && ofs < OFS_OUT + n_out)
         return RGN_OUT;
      if (ofs >= OFS_IN && ofs < OFS_IN + n_in)
         return RGN_IN;
      if (ofs == OFS_STAT)
         return RGN_STAT;
      if (ofs == OFS_MASK)
         return RGN_MASK;
      return RGN_NONE;
   endfunction

   // Replace the bytes of old_w whose enable bit is set with those of new_w.
   function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
      logic [31:0] r;
      r = old_w;
      for (int i = 0; i < 4; i++) begin
         if (be[i])
            r[8*i +: 8] = new_w[8*i +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/pipe_datamem_mmio_io_in_sync.sv
// One input port: 2-flop synchroniser plus a previous-sample register for change detection.
// Ports: clock_i/clr_i (async active-high reset), pin_i raw input, value_o synchronised value,
//        chg_o high while the synchronised value differs from the previous sample.
module io_in_sync #(
   parameter int W = 4
) (
   input  logic         clock_i,
   input  logic         clr_i,
   input  logic [W-1:0] pin_i,
   output logic [W-1:0] value_o,
   output logic         chg_o
);

   logic [W-1:0] s1_q;
   logic [W-1:0] s2_q;
   logic [W-1:0] prev_q;

   always_ff @(posedge clock_i or posedge clr_i) begin
      if (clr_i) begin
         s1_q   <= '0;
         s2_q   <= '0;
         prev_q <= '0;
      end else begin
         s1_q   <= pin_i;
         s2_q   <= s1_q;
         prev_q <= s2_q;
      end
   end

   assign value_o = s2_q;
   // Combinational compare: the owning status flag registers it one edge later,
   // so a pin change is first visible in status 3 edges after it happens.
   assign chg_o   = (s2_q != prev_q);

endmodule

// File: rtl/pipe_datamem_mmio.sv
// Data memory with memory-mapped I/O for the pipelined CPU's MEM stage.
// Ports: clock, clr (async active-high reset), addr/datain/we/be/re bus from the MEM stage,
//        in_ports async inputs, dataout registered read data (1-cycle latency, read-first),
//        out_ports output registers, irq = registered |(status & mask).
module pipe_datamem_mmio
   import pipe_mmio_pkg::*;
#(
   parameter int          DEPTH     = 32,
   parameter int          IO_BIT    = 7,
   parameter int          N_OUT     = 2,
   parameter int          N_IN      = 2,
   parameter int          IN_W      = 4,
   parameter logic [31:0] OUT_RESET = 32'h0
) (
   input  logic                   clock,
   input  logic                   clr,
   input  logic [31:0]            addr,
   input  logic [31:0]            datain,
   input  logic                   we,
   input  logic [3:0]             be,
   input  logic                   re,
   input  logic [N_IN*IN_W-1:0]   in_ports,
   output logic [31:0]            dataout,
   output logic [N_OUT*32-1:0]    out_ports,
   output logic                   irq
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // ---------------------------------------------------------------- decode
   region_t       rgn;
   logic [AW-1:0] widx;
   logic [2:0]    sel;      // port index within the out/in groups (offsets 0.. and 8..)
   logic          unused_addr;

   assign rgn         = region_decode(addr, IO_BIT, N_OUT, N_IN);
   assign widx        = addr[AW+1:2];   // upper index bits below IO_BIT alias
   assign sel         = addr[4:2];
   assign unused_addr = ^addr;

   // ---------------------------------------------------------------- RAM
   logic [31:0] mem_q [DEPTH];

   // No reset on the array so it maps onto plain RAM.
   always_ff @(posedge clock) begin
      if (we && rgn == RGN_RAM)
         mem_q[widx] <= byte_merge(mem_q[widx], datain, be);
   end

   // ---------------------------------------------------------------- inputs
   logic [IN_W-1:0] in_val [N_IN];
   logic [N_IN-1:0] in_chg;

   for (genvar k = 0; k < N_IN; k++) begin : g_in
      io_in_sync #(.W(IN_W)) u_sync (
         .clock_i (clock),
         .clr_i   (clr),
         .pin_i   (in_ports[k*IN_W +: IN_W]),
         .value_o (in_val[k]),
         .chg_o   (in_chg[k])
      );
   end

   // ---------------------------------------------------------------- registers
   logic [31:0]     out_q [N_OUT];
   logic [31:0]     out_d [N_OUT];
   logic [N_IN-1:0] mask_q, mask_d;
   logic [N_IN-1:0] status_q, status_d;
   logic            irq_q, irq_d;
   logic [31:0]     dataout_q, dataout_d;

   always_comb begin
      for (int k = 0; k < N_OUT; k++)
         out_d[k] = out_q[k];
      if (we && rgn == RGN_OUT) begin
         for (int k = 0; k < N_OUT; k++) begin
            if (sel == k[2:0])
               out_d[k] = byte_merge(out_q[k], datain, be);
         end
      end
   end

   always_comb begin
      mask_d = mask_q;
      if (we && rgn == RGN_MASK && be[0])
         mask_d = datain[N_IN-1:0];
   end

   // Clear-on-read happens first, then new change events are OR'd in,
   // so an event landing on the clearing edge survives.
   always_comb begin
      status_d = status_q;
      if (re && rgn == RGN_STAT)
         status_d = '0;
      status_d = status_d | in_chg;
   end

   assign irq_d = |(status_q & mask_q);

   // Read mux samples current (pre-edge) state, giving read-first behaviour.
   always_comb begin
      dataout_d = '0;
      case (rgn)
         RGN_RAM: dataout_d = mem_q[widx];
         RGN_OUT: begin
            for (int k = 0; k < N_OUT; k++) begin
               if (sel == k[2:0])
                  dataout_d = out_q[k];
            end
         end
         RGN_IN: begin
            for (int k = 0; k < N_IN; k++) begin
               if (sel == k[2:0])
                  dataout_d[IN_W-1:0] = in_val[k];
            end
         end
         RGN_STAT: dataout_d[N_IN-1:0] = status_q;
         RGN_MASK: dataout_d[N_IN-1:0] = mask_q;
         default:  dataout_d = '0;
      endcase
   end

   always_ff @(posedge clock or posedge clr) begin
      if (clr) begin
         for (int k = 0; k < N_OUT; k++)
            out_q[k] <= OUT_RESET;
         mask_q    <= '0;
         status_q  <= '0;
         irq_q     <= 1'b0;
         dataout_q <= '0;
      end else begin
         for (int k = 0; k < N_OUT; k++)
            out_q[k] <= out_d[k];
         mask_q    <= mask_d;
         status_q  <= status_d;
         irq_q     <= irq_d;
         dataout_q <= dataout_d;
      end
   end

   // ---------------------------------------------------------------- outputs
   for (genvar k = 0; k < N_OUT; k++) begin : g_out
      assign out_ports[k*32 +: 32] = out_q[k];
   end

   assign dataout = dataout_q;
   assign irq     = irq_q;

endmodule

// File: tb/tb_pipe_datamem_mmio.sv
module tb_pipe_datamem_mmio;

   logic        clock = 1'b0;
   logic        clr;
   logic [31:0] addr;
   logic [31:0] datain;
   logic        we;
   logic [3:0]  be;
   logic        re;
   logic [7:0]  in_ports;
   logic [31:0] dataout;
   logic [63:0] out_ports;
   logic        irq;

   int total = 0;
   int bad   = 0;

   pipe_datamem_mmio #(
      .DEPTH(32), .IO_BIT(7), .N_OUT(2), .N_IN(2), .IN_W(4), .OUT_RESET(32'h0)
   ) dut (
      .clock     (clock),
      .clr       (clr),
      .addr      (addr),
      .datain    (datain),
      .we        (we),
      .be        (be),
      .re        (re),
      .in_ports  (in_ports),
      .dataout   (dataout),
      .out_ports (out_ports),
      .irq       (irq)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        we;
      logic        re;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdat;
      logic        chk;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic w, input logic r, input logic [3:0] b,
                               input logic [31:0] a, input logic [31:0] d,
                               input logic c, input logic [31:0] e);
      vec_t v;
      v.we = w; v.re = r; v.be = b; v.addr = a; v.wdat = d; v.chk = c; v.exp_rd = e;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive a bus cycle on the falling edge, sample 1 time unit after the rising edge.
   task automatic cyc(input logic w, input logic r, input logic [3:0] b,
                      input logic [31:0] a, input logic [31:0] d);
      @(negedge clock);
      we = w; re = r; be = b; addr = a; datain = d;
      @(posedge clock);
      #1;
   endtask

   task automatic rd(input logic [31:0] a);
      cyc(1'b0, 1'b0, 4'h0, a, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      clr = 1'b1; addr = '0; datain = '0; we = 0; be = 0; re = 0; in_ports = '0;

      // Vectors: read-first data returned for the cycle's address, then follow-up reads.
      vecs.push_back(mk(1, 0, 4'hF, 32'h0C, 32'h11223344, 0, 32'h0));
      vecs.push_back(mk(1, 0, 4'h5, 32'h0C, 32'hAABBCCDD, 1, 32'h11223344));
      vecs.push_back(mk(0, 0, 4'h0, 32'h0C, 32'h0,        1, 32'h11BB33DD));
      vecs.push_back(mk(1, 0, 4'hF, 32'h10, 32'h01020304, 0, 32'h0));
      vecs.push_back(mk(1, 0, 4'hF, 32'h10, 32'hDEADBEEF, 1, 32'h01020304));
      vecs.push_back(mk(0, 0, 4'h0, 32'h10, 32'h0,        1, 32'hDEADBEEF));
      vecs.push_back(mk(0, 0, 4'h0, 32'h0C, 32'h0,        1, 32'h11BB33DD));
      vecs.push_back(mk(1, 0, 4'hF, 32'h84, 32'h5,        1, 32'h0));
      vecs.push_back(mk(0, 0, 4'h0, 32'h84, 32'h0,        1, 32'h5));
      vecs.push_back(mk(1, 0, 4'h3, 32'h80, 32'hCAFEF00D, 1, 32'h0));
      vecs.push_back(mk(0, 0, 4'h0, 32'h80, 32'h0,        1, 32'h0000F00D));
      vecs.push_back(mk(1, 0, 4'hF, 32'h88, 32'hFFFFFFFF, 1, 32'h0));
      vecs.push_back(mk(0, 0, 4'h0, 32'h88, 32'h0,        1, 32'h0));
      vecs.push_back(mk(1, 0, 4'hF, 32'hA0, 32'hFFFFFFFF, 1, 32'h0));
      vecs.push_back(mk(0, 0, 4'h0, 32'hA0, 32'h0,        1, 32'h0));
      vecs.push_back(mk(1, 0, 4'hE, 32'hC4, 32'hFFFFFFFF, 1, 32'h0));
      vecs.push_back(mk(0, 0, 4'h0, 32'hC4, 32'h0,        1, 32'h0));
      vecs.push_back(mk(1, 0, 4'h1, 32'hC4, 32'h2,        1, 32'h0));
      vecs.push_back(mk(0, 0, 4'h0, 32'hC4, 32'h0,        1, 32'h2));
      vecs.push_back(mk(1, 0, 4'hF, 32'hC0, 32'hFFFFFFFF, 1, 32'h0));
      vecs.push_back(mk(0, 0, 4'h0, 32'h8C, 32'h0,        1, 32'h0));

      #1;
      check("reset_dataout", {32'h0, dataout}, 64'h0);
      check("reset_out_ports", out_ports, 64'h0);
      check("reset_irq", {63'h0, irq}, 64'h0);

      @(negedge clock);
      clr = 1'b0;

      foreach (vecs[i]) begin
         cyc(vecs[i].we, vecs[i].re, vecs[i].be, vecs[i].addr, vecs[i].wdat);
         if (vecs[i].chk)
            check($sformatf("vec%0d_dataout", i), {32'h0, dataout}, {32'h0, vecs[i].exp_rd});
      end
      check("out_ports_after_writes", out_ports, {32'h5, 32'h0000F00D});

      // Input port 1 -> 0xA: synchroniser latency, status at edge 3, irq at edge 4.
      @(negedge clock);
      in_ports = 8'hA0;
      we = 0; re = 0; addr = 32'hA4;
      @(posedge clock); #1;
      check("in1_edge1", {32'h0, dataout}, 64'h0);
      @(posedge clock); #1;
      check("in1_edge2", {32'h0, dataout}, 64'h0);
      @(posedge clock); #1;
      check("in1_edge3", {32'h0, dataout}, 64'hA);
      check("irq_edge3", {63'h0, irq}, 64'h0);
      @(posedge clock); #1;
      check("irq_edge4", {63'h0, irq}, 64'h1);
      cyc(0, 1, 4'h0, 32'hC0, 32'h0);
      check("status_read", {32'h0, dataout}, 64'h2);
      rd(32'hC0);
      check("status_cleared", {32'h0, dataout}, 64'h0);
      check("irq_cleared", {63'h0, irq}, 64'h0);

      // Set-wins: port 0 change lands on the status-read edge.
      @(negedge clock);
      in_ports = 8'hA5;
      addr = 32'h0C;
      @(posedge clock); #1;
      @(posedge clock); #1;
      cyc(0, 1, 4'h0, 32'hC0, 32'h0);
      check("setwins_old_flags", {32'h0, dataout}, 64'h0);
      rd(32'hC0);
      check("setwins_bit0_kept", {32'h0, dataout}, 64'h1);
      check("irq_masked", {63'h0, irq}, 64'h0);

      // Unmask bit 0 so irq rises, then reset mid-cycle.
      cyc(1, 0, 4'h1, 32'hC4, 32'h3);
      rd(32'h84);
      check("irq_unmasked", {63'h0, irq}, 64'h1);
      check("pre_reset_dataout", {32'h0, dataout}, 64'h5);
      @(negedge clock);
      #2;
      clr = 1'b1;
      #1;
      check("async_reset_out_ports", out_ports, 64'h0);
      check("async_reset_dataout", {32'h0, dataout}, 64'h0);
      check("async_reset_irq", {63'h0, irq}, 64'h0);
      @(negedge clock);
      clr = 1'b0;
      rd(32'hC4);
      check("mask_after_reset", {32'h0, dataout}, 64'h0);
      rd(32'h0C);
      check("ram_kept_over_reset", {32'h0, dataout}, 64'h11BB33DD);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
